// File: rtl/div_unit_if.sv
// Request/response bundle between EX and the iterative divider.
// Master drives operands and controls; slave returns {rem, quo}.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
    output annul_i,
    input  result_o,
    input  ready_o
  );

  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
    input  annul_i,
    output result_o,
    output ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; one quotient bit per clock.
// Result packs remainder in hi and quotient in lo.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sgn_q, sgn_d;
  logic               n1_q, n1_d;
  logic               n2_q, n2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH:0]     shifted, diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_step, quo_step;
  logic [WIDTH-1:0]   rem_fin, quo_fin;
  logic               neg1, neg2;

  // Datapath is WIDTH+1 wide so a 2^(WIDTH-1) magnitude never overflows.
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    ge       = shifted >= {1'b0, dvs_q};
    rem_step = WIDTH'(ge ? diff : shifted);
    quo_step = {dvd_q[WIDTH-2:0], ge};
    quo_fin  = (sgn_q && (n1_q != n2_q)) ? -quo_step : quo_step;
    rem_fin  = (sgn_q && n1_q) ? -rem_step : rem_step;
    neg1     = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    neg2     = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    sgn_d    = sgn_q;
    n1_d     = n1_q;
    n2_d     = n2_q;
    result_d = result_q;
    ready_d  = ready_q;
    unique case (state_q)
      FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = BYZERO;
          end else begin
            state_d = ON;
            sgn_d   = bus.signed_div_i;
            n1_d    = neg1;
            n2_d    = neg2;
            dvd_d   = neg1 ? -bus.opdata1_i : bus.opdata1_i;
            dvs_d   = neg2 ? -bus.opdata2_i : bus.opdata2_i;
            rem_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      BYZERO: begin
        if (bus.annul_i) begin
          state_d = FREE;
        end else begin
          state_d  = END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      ON: begin
        if (bus.annul_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
          rem_d    = '0;
          cnt_d    = '0;
        end else begin
          rem_d = rem_step;
          dvd_d = quo_step;
          cnt_d = cnt_q + 1'b1;
          // Last step loads the signed-corrected result directly.
          if (cnt_q == LAST) begin
            state_d  = END;
            result_d = {rem_fin, quo_fin};
            ready_d  = 1'b1;
          end
        end
      end
      END: begin
        if (!bus.start_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      sgn_q    <= 1'b0;
      n1_q     <= 1'b0;
      n2_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      sgn_q    <= sgn_d;
      n1_q     <= n1_d;
      n2_q     <= n2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// Randomised and directed checks of div_unit at WIDTH=32 and WIDTH=8.
// Reference results come from plain integer / and % on sign-extended values.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;

  int vec_cnt = 0;
  int err_cnt = 0;

  div_unit_if #(.WIDTH(32)) b32 ();
  div_unit_if #(.WIDTH(8))  b8 ();

  div_unit #(.WIDTH(32)) u_div32 (
    .clk (clk),
    .rst (rst),
    .bus (b32.slave)
  );

  div_unit #(.WIDTH(8)) u_div8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Truncating division of the sign-extended operands; wraps to w bits.
  function automatic logic [63:0] model(int w, bit s,
                                        logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] m;
    m  = (64'd1 << w) - 64'd1;
    sa = longint'({32'd0, a});
    sb = longint'({32'd0, b});
    if (s && a[w-1]) sa = sa - longint'(64'd1 << w);
    if (s && b[w-1]) sb = sb - longint'(64'd1 << w);
    if (sb == 0) return 64'd0;
    q = sa / sb;
    r = sa % sb;
    return ((64'(r) & m) << w) | (64'(q) & m);
  endfunction

  task automatic drive(int w, bit s, logic [31:0] a, logic [31:0] b,
                       bit st, bit an);
    if (w == 32) begin
      b32.signed_div_i = s;
      b32.opdata1_i    = a;
      b32.opdata2_i    = b;
      b32.start_i      = st;
      b32.annul_i      = an;
    end else begin
      b8.signed_div_i = s;
      b8.opdata1_i    = a[7:0];
      b8.opdata2_i    = b[7:0];
      b8.start_i      = st;
      b8.annul_i      = an;
    end
  endtask

  task automatic sample(int w, output bit rdy, output logic [63:0] res);
    if (w == 32) begin
      rdy = b32.ready_o;
      res = b32.result_o;
    end else begin
      rdy = b8.ready_o;
      res = {48'd0, b8.result_o};
    end
  endtask

  // Start with start held, optionally with annul held for pre cycles first.
  task automatic run_op(int w, bit s, logic [31:0] a, logic [31:0] b,
                        logic [63:0] exp, int lat, int pre);
    int n;
    bit rdy;
    bit early;
    logic [63:0] res;
    @(negedge clk);
    drive(w, s, a, b, 1'b1, pre > 0);
    early = 1'b0;
    if (pre > 0) begin
      repeat (pre) begin
        @(posedge clk);
        #1;
        sample(w, rdy, res);
        early = early | rdy;
      end
      chk("annul_free", 64'(early), 64'd0);
      @(negedge clk);
      drive(w, s, a, b, 1'b1, 1'b0);
    end
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1)
        drive(w, ~s, $urandom, $urandom, 1'b1, 1'b0);
      sample(w, rdy, res);
    end
    chk("latency", 64'(n), 64'(lat));
    chk("result", res, exp);
    @(negedge clk);
    drive(w, s, $urandom, $urandom, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    sample(w, rdy, res);
    chk("end_hold", {63'd0, rdy}, 64'd1);
    chk("end_res", res, exp);
    @(negedge clk);
    drive(w, s, a, b, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    sample(w, rdy, res);
    chk("clr_rdy", {63'd0, rdy}, 64'd0);
    chk("clr_res", res, 64'd0);
  endtask

  initial begin
    bit s;
    bit rdy;
    int seen;
    logic [31:0] a, b;
    logic [63:0] res;

    drive(32, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #12;
    chk("rst_rdy32", {63'd0, b32.ready_o}, 64'd0);
    chk("rst_res32", b32.result_o, 64'd0);
    chk("rst_res8", {48'd0, b8.result_o}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op(32, 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);
    run_op(32, 1'b1, 32'hFFFFFFF9, 32'd2,
           {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0);
    run_op(32, 1'b1, 32'd7, 32'hFFFFFFFE,
           {32'h00000001, 32'hFFFFFFFD}, 33, 0);
    run_op(32, 1'b0, 32'h1234, 32'd0, 64'd0, 2, 0);
    run_op(32, 1'b1, 32'h80000000, 32'hFFFFFFFF,
           {32'd0, 32'h80000000}, 33, 0);
    run_op(32, 1'b0, 32'd55, 32'd6, {32'd1, 32'd9}, 33, 4);

    // Annul in the middle of the iteration, then a clean restart.
    @(negedge clk);
    drive(32, 1'b0, 32'd1000, 32'd3, 1'b1, 1'b0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    drive(32, 1'b0, 32'd1000, 32'd3, 1'b0, 1'b1);
    @(negedge clk);
    drive(32, 1'b0, 32'd1000, 32'd3, 1'b0, 1'b0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (b32.ready_o) seen++;
    end
    chk("annul_rdy", 64'(seen), 64'd0);
    chk("annul_res", b32.result_o, 64'd0);
    run_op(32, 1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, 33, 0);

    // Async reset while a result is being held.
    @(negedge clk);
    drive(32, 1'b0, 32'd77, 32'd7, 1'b1, 1'b0);
    repeat (33) @(posedge clk);
    #1;
    chk("pre_rst_rdy", {63'd0, b32.ready_o}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_rdy", {63'd0, b32.ready_o}, 64'd0);
    chk("arst_res", b32.result_o, 64'd0);
    drive(32, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Async reset mid-iteration.
    @(negedge clk);
    drive(32, 1'b0, 32'd500, 32'd9, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b0;
    drive(32, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("mid_rst_res", b32.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(32, 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33, 0);

    run_op(8, 1'b0, 32'd200, 32'd3, 64'h0242, 9, 0);
    run_op(8, 1'b1, 32'h80, 32'h01, 64'h0080, 9, 0);
    run_op(8, 1'b1, 32'h80, 32'hFF, 64'h0080, 9, 0);
    run_op(8, 1'b1, 32'h9C, 32'h07, 64'hFEF2, 9, 0);
    run_op(8, 1'b0, 32'hFF, 32'h00, 64'h0000, 2, 0);

    for (int i = 0; i < 200; i++) begin
      s = 1'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      run_op(32, s, a, b, model(32, s, a, b), (b == 0) ? 2 : 33, 0);
    end

    for (int i = 0; i < 2000; i++) begin
      s = 1'($urandom);
      a = {24'd0, 8'($urandom)};
      b = {24'd0, 8'($urandom)};
      if ($urandom_range(0, 15) == 0) b = 32'd0;
      run_op(8, s, a, b, model(8, s, a, b), (b == 0) ? 2 : 9, 0);
    end

    sample(8, rdy, res);
    chk("final_rdy8", {63'd0, rdy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end
endmodule
